// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between fetch and load/store.
// Handles request/ack sequencing, store lane steering and load extension.
`ifndef MEM_WRITE_LEN
`define MEM_WRITE_LEN 2
`endif
`ifndef MEM_TYPE_LEN
`define MEM_TYPE_LEN 3
`endif
`ifndef M_X
`define M_X 2'd0
`endif
`ifndef M_R
`define M_R 2'd1
`endif
`ifndef M_W
`define M_W 2'd2
`endif
`ifndef MT_X
`define MT_X 3'd0
`endif
`ifndef MT_B
`define MT_B 3'd1
`endif
`ifndef MT_H
`define MT_H 3'd2
`endif
`ifndef MT_W
`define MT_W 3'd3
`endif
`ifndef MT_BU
`define MT_BU 3'd4
`endif
`ifndef MT_HU
`define MT_HU 3'd5
`endif

module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      if_req,
  input  logic [31:0]               if_addr,
  input  logic                      if_kill,
  output logic                      if_ready,
  output logic [31:0]               if_rdata,
  input  logic                      d_req,
  input  logic [31:0]               d_addr,
  input  logic [`MEM_WRITE_LEN-1:0] d_rw,
  input  logic [`MEM_TYPE_LEN-1:0]  d_type,
  input  logic [31:0]               d_wdata,
  output logic                      d_ready,
  output logic                      d_err,
  output logic [31:0]               d_rdata,
  output logic                      mem_req,
  output logic [31:0]               mem_addr,
  output logic                      mem_we,
  output logic [3:0]                mem_be,
  output logic [31:0]               mem_wdata,
  input  logic                      mem_ack,
  input  logic [31:0]               mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, IF_BUSY, D_BUSY, D_ERR
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t                    state_q, state_d;
  logic [7:0]                starve_q, starve_d;
  logic                      kill_q, kill_d;
  logic [1:0]                lane_q, lane_d;
  logic [`MEM_TYPE_LEN-1:0]  type_q, type_d;
  logic                      wr_q, wr_d;
  logic                      if_ready_q, if_ready_d;
  logic [31:0]               if_rdata_q, if_rdata_d;
  logic                      d_ready_q, d_ready_d;
  logic                      d_err_q, d_err_d;
  logic [31:0]               d_rdata_q, d_rdata_d;
  logic                      mem_req_q, mem_req_d;
  logic [31:0]               mem_addr_q, mem_addr_d;
  logic                      mem_we_q, mem_we_d;
  logic [3:0]                mem_be_q, mem_be_d;
  logic [31:0]               mem_wdata_q, mem_wdata_d;

  logic        is_b, is_h, is_w;
  logic        d_bad, d_pick, i_pick;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;
  logic        unused_ok;

  assign unused_ok = &{1'b0, if_addr[1:0]};

  assign is_b = (d_type == `MT_B) || (d_type == `MT_BU);
  assign is_h = (d_type == `MT_H) || (d_type == `MT_HU);
  assign is_w = (d_type == `MT_W);

  // Unknown encodings and misalignment both end in D_ERR
  assign d_bad = !((d_rw == `M_R) || (d_rw == `M_W))
              || !(is_b || is_h || is_w)
              || (is_h && d_addr[0])
              || (is_w && (d_addr[1:0] != 2'b00));

  assign d_pick = d_req && (!if_req || (starve_q < LIMIT));
  assign i_pick = !d_pick && if_req && !if_kill;

  assign ld_b = mem_rdata[{lane_q, 3'b000} +: 8];
  assign ld_h = mem_rdata[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_val = mem_rdata;
    unique case (1'b1)
      type_q == `MT_B:  ld_val = {{24{ld_b[7]}}, ld_b};
      type_q == `MT_BU: ld_val = {24'd0, ld_b};
      type_q == `MT_H:  ld_val = {{16{ld_h[15]}}, ld_h};
      type_q == `MT_HU: ld_val = {16'd0, ld_h};
      default:          ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    kill_d      = kill_q;
    lane_d      = lane_q;
    type_d      = type_q;
    wr_d        = wr_q;
    if_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_ready_d   = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (d_pick) begin
          if (!if_req)
            starve_d = 8'd0;
          else if (starve_q != 8'hFF)
            starve_d = starve_q + 8'd1;
          lane_d = d_addr[1:0];
          type_d = d_type;
          wr_d   = (d_rw == `M_W);
          if (d_bad) begin
            state_d = D_ERR;
          end else begin
            state_d     = D_BUSY;
            mem_addr_d  = {d_addr[31:2], 2'b00};
            mem_we_d    = (d_rw == `M_W);
            mem_be_d    = 4'b1111;
            mem_wdata_d = 32'd0;
            if (d_rw == `M_W) begin
              unique case (1'b1)
                is_b: begin
                  mem_be_d    = 4'b0001 << d_addr[1:0];
                  mem_wdata_d = {4{d_wdata[7:0]}};
                end
                is_h: begin
                  mem_be_d    = 4'b0011 << {d_addr[1], 1'b0};
                  mem_wdata_d = {2{d_wdata[15:0]}};
                end
                default: mem_wdata_d = d_wdata;
              endcase
            end
          end
        end else if (i_pick) begin
          starve_d    = 8'd0;
          state_d     = IF_BUSY;
          mem_addr_d  = {if_addr[31:2], 2'b00};
          mem_we_d    = 1'b0;
          mem_be_d    = 4'b1111;
          mem_wdata_d = 32'd0;
        end
      end
      IF_BUSY: begin
        if (if_kill)
          kill_d = 1'b1;
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          kill_d    = 1'b0;
          if (!kill_q && !if_kill) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      D_BUSY: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          d_ready_d = 1'b1;
          d_rdata_d = wr_q ? 32'd0 : ld_val;
        end
      end
      D_ERR: begin
        d_ready_d = 1'b1;
        d_err_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= 8'd0;
      kill_q      <= 1'b0;
      lane_q      <= 2'd0;
      type_q      <= '0;
      wr_q        <= 1'b0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_ready_q   <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      kill_q      <= kill_d;
      lane_q      <= lane_d;
      type_q      <= type_d;
      wr_q        <= wr_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_ready_q   <= d_ready_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, scoreboard queues and
// hand-written starvation, kill and reset sequences.
`ifndef MEM_WRITE_LEN
`define MEM_WRITE_LEN 2
`endif
`ifndef MEM_TYPE_LEN
`define MEM_TYPE_LEN 3
`endif
`ifndef M_X
`define M_X 2'd0
`endif
`ifndef M_R
`define M_R 2'd1
`endif
`ifndef M_W
`define M_W 2'd2
`endif
`ifndef MT_X
`define MT_X 3'd0
`endif
`ifndef MT_B
`define MT_B 3'd1
`endif
`ifndef MT_H
`define MT_H 3'd2
`endif
`ifndef MT_W
`define MT_W 3'd3
`endif
`ifndef MT_BU
`define MT_BU 3'd4
`endif
`ifndef MT_HU
`define MT_HU 3'd5
`endif

module tb_mem_port_arbiter;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      if_req, if_kill, if_ready;
  logic [31:0]               if_addr, if_rdata;
  logic                      d_req, d_ready, d_err;
  logic [31:0]               d_addr, d_wdata, d_rdata;
  logic [`MEM_WRITE_LEN-1:0] d_rw;
  logic [`MEM_TYPE_LEN-1:0]  d_type;
  logic                      mem_req, mem_we, mem_ack;
  logic [31:0]               mem_addr, mem_wdata, mem_rdata;
  logic [3:0]                mem_be;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_rw(d_rw),
    .d_type(d_type), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [`MEM_WRITE_LEN-1:0] rw;
    logic [`MEM_TYPE_LEN-1:0]  ty;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          dly;
    logic        err;
    logic [31:0] exp_rd;
    logic        we;
    logic [3:0]  be;
    logic [31:0] exp_wd;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    logic        chk_rd;
  } dexp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } mexp_t;

  dexp_t       dq[$];
  logic [31:0] iq[$];
  mexp_t       mq[$];

  int          n_vec = 0;
  int          n_bad = 0;
  int          ack_dly = 0;
  int          n_rdy = 0;
  logic [31:0] rdata_cfg = 32'd0;
  logic        addr_mode = 1'b0;
  logic        model_on = 1'b1;
  logic        chk_mem = 1'b1;
  logic [9:0]  gseq = 10'd0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory model: acks ack_dly cycles after first seeing mem_req
  initial begin : mem_model
    int wcnt;
    mexp_t m;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (model_on) begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (wcnt >= ack_dly) begin
            mem_ack = 1'b1;
            mem_rdata = addr_mode ? (32'hA5A50000 ^ mem_addr)
                                  : rdata_cfg;
            wcnt = 0;
            if (chk_mem) begin
              if (mq.size() == 0) begin
                chk("unexpected_mem_access", 32'd1, 32'd0);
              end else begin
                m = mq.pop_front();
                chk("mem_addr", mem_addr, m.addr);
                chk("mem_we", 32'(mem_we), 32'(m.we));
                chk("mem_be", 32'(mem_be), 32'(m.be));
                if (m.we) chk("mem_wdata", mem_wdata, m.wd);
              end
            end
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
        end
      end
    end
  end

  // Scoreboard side: pop expectations as ready pulses appear
  initial begin : monitor
    dexp_t e;
    logic [31:0] iexp;
    forever begin
      @(negedge clk);
      if (d_ready) begin
        n_rdy++;
        gseq = {gseq[8:0], 1'b0};
        if (dq.size() == 0) begin
          chk("unexpected_d_ready", 32'd1, 32'd0);
        end else begin
          e = dq.pop_front();
          chk("d_err", 32'(d_err), 32'(e.err));
          if (e.chk_rd) chk("d_rdata", d_rdata, e.rd);
        end
      end
      if (if_ready) begin
        n_rdy++;
        gseq = {gseq[8:0], 1'b1};
        if (iq.size() == 0) begin
          chk("unexpected_if_ready", 32'd1, 32'd0);
        end else begin
          iexp = iq.pop_front();
          chk("if_rdata", if_rdata, iexp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  vec_t tv[14];

  initial begin : main
    vec_t v;
    int edges, cyc, n, r0;
    logic got, saw;

    //        rw     ty      addr          wd            rdata   dly err exp_rd       we  be       exp_wd
    tv[0]  = '{`M_R, `MT_W,  32'h100, 32'h0,        32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0, 4'b1111, 32'h0};
    tv[1]  = '{`M_R, `MT_B,  32'h103, 32'h0,        32'h80112233, 0, 0, 32'hFFFFFF80, 0, 4'b1111, 32'h0};
    tv[2]  = '{`M_R, `MT_BU, 32'h103, 32'h0,        32'h80112233, 2, 0, 32'h00000080, 0, 4'b1111, 32'h0};
    tv[3]  = '{`M_R, `MT_HU, 32'h102, 32'h0,        32'h80112233, 1, 0, 32'h00008011, 0, 4'b1111, 32'h0};
    tv[4]  = '{`M_R, `MT_H,  32'h100, 32'h0,        32'h80118000, 0, 0, 32'hFFFF8000, 0, 4'b1111, 32'h0};
    tv[5]  = '{`M_R, `MT_B,  32'h101, 32'h0,        32'h80112233, 1, 0, 32'h00000022, 0, 4'b1111, 32'h0};
    tv[6]  = '{`M_W, `MT_B,  32'h201, 32'h000000AB, 32'h55555555, 1, 0, 32'h0,        1, 4'b0010, 32'hABABABAB};
    tv[7]  = '{`M_W, `MT_H,  32'h202, 32'h1234CDEF, 32'h55555555, 0, 0, 32'h0,        1, 4'b1100, 32'hCDEFCDEF};
    tv[8]  = '{`M_W, `MT_W,  32'h204, 32'h01020304, 32'h55555555, 2, 0, 32'h0,        1, 4'b1111, 32'h01020304};
    tv[9]  = '{`M_W, `MT_H,  32'h203, 32'h0000BEEF, 32'h0,        0, 1, 32'h0,        0, 4'b0000, 32'h0};
    tv[10] = '{`M_R, `MT_W,  32'h102, 32'h0,        32'h0,        0, 1, 32'h0,        0, 4'b0000, 32'h0};
    tv[11] = '{`M_X, `MT_W,  32'h100, 32'h0,        32'h0,        0, 1, 32'h0,        0, 4'b0000, 32'h0};
    tv[12] = '{`M_R, `MT_X,  32'h100, 32'h0,        32'h0,        0, 1, 32'h0,        0, 4'b0000, 32'h0};
    tv[13] = '{`M_R, `MT_HU, 32'h101, 32'h0,        32'h0,        0, 1, 32'h0,        0, 4'b0000, 32'h0};

    reset = 1'b1;
    if_req = 0; if_kill = 0; if_addr = 0;
    d_req = 0; d_addr = 0; d_rw = `M_R;
    d_type = `MT_W; d_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl",
        32'({mem_req, mem_we, mem_be, if_ready, d_ready, d_err}),
        32'd0);
    chk("reset_data",
        mem_addr | mem_wdata | d_rdata | if_rdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      v = tv[i];
      ack_dly = v.dly;
      rdata_cfg = v.rdata;
      dq.push_back('{v.err, v.exp_rd, !v.err});
      if (!v.err)
        mq.push_back('{{v.addr[31:2], 2'b00}, v.we, v.be, v.exp_wd});
      @(posedge clk); #1;
      d_rw = v.rw; d_type = v.ty;
      d_addr = v.addr; d_wdata = v.wd;
      d_req = 1'b1;
      edges = 0; got = 0; saw = 0;
      while (!got && edges < 40) begin
        @(posedge clk); #1;
        edges++;
        if (mem_req) saw = 1;
        if (d_ready) got = 1;
      end
      d_req = 1'b0;
      chk($sformatf("v%0d_ready_seen", i), 32'(got), 32'd1);
      chk($sformatf("v%0d_latency", i), 32'(edges),
          v.err ? 32'd2 : 32'(3 + v.dly));
      if (v.err) chk($sformatf("v%0d_no_mem_req", i), 32'(saw), 32'd0);
    end

    // Both requesters held: data is forced to yield every 5th grant
    @(posedge clk); #1;
    chk_mem = 0; ack_dly = 0; rdata_cfg = 32'h00000013;
    for (int i = 0; i < 8; i++) dq.push_back('{1'b0, 32'h13, 1'b1});
    for (int i = 0; i < 2; i++) iq.push_back(32'h13);
    gseq = 10'd0;
    d_rw = `M_R; d_type = `MT_W; d_addr = 32'h10;
    if_addr = 32'h400;
    if_req = 1; d_req = 1;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (d_ready || if_ready) n++;
    end
    if_req = 0; d_req = 0;
    chk("starve_ready_count", 32'(n), 32'd10);
    repeat (3) @(posedge clk);
    chk("grant_seq", 32'(gseq), 32'b0000100001);

    // Killed fetch: no if_ready, next grant is the redirected fetch
    chk_mem = 1; addr_mode = 1; ack_dly = 3;
    mq.push_back('{32'h500, 1'b0, 4'b1111, 32'h0});
    mq.push_back('{32'h600, 1'b0, 4'b1111, 32'h0});
    iq.push_back(32'hA5A50600);
    @(posedge clk); #1;
    if_addr = 32'h500; if_req = 1;
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("kill_mem_req_seen", 32'(mem_req), 32'd1);
    if_kill = 1; if_addr = 32'h600;
    @(posedge clk); #1;
    if_kill = 0;
    r0 = n_rdy;
    got = 0; cyc = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (if_ready) got = 1;
    end
    if_req = 0;
    chk("kill_redirect_ready", 32'(got), 32'd1);
    chk("kill_single_ready", 32'(n_rdy - r0), 32'd0);
    repeat (2) @(posedge clk);
    chk("kill_ready_total", 32'(n_rdy - r0), 32'd1);

    // Reset while the memory has not answered
    addr_mode = 0; chk_mem = 0; model_on = 0;
    mem_ack = 0;
    @(posedge clk); #1;
    d_rw = `M_R; d_type = `MT_W; d_addr = 32'h700; d_req = 1;
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("rst_mem_req_seen", 32'(mem_req), 32'd1);
    reset = 1; d_req = 0;
    @(posedge clk); #1;
    chk("rst_mid_ctrl",
        32'({mem_req, mem_we, mem_be, if_ready, d_ready, d_err}),
        32'd0);
    chk("rst_mid_data",
        mem_addr | mem_wdata | d_rdata | if_rdata, 32'd0);
    reset = 0;
    r0 = n_rdy;
    @(negedge clk); mem_ack = 1; mem_rdata = 32'h12345678;
    repeat (2) @(negedge clk);
    mem_ack = 0;
    saw = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_req) saw = 1;
    end
    chk("rst_no_ready", 32'(n_rdy - r0), 32'd0);
    chk("rst_no_mem_req", 32'(saw), 32'd0);

    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("mq_drained", 32'(mq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between instruction fetch (IF) and the MEM-stage load/store path.
- Sequences each access as a multi-cycle request/acknowledge transaction.
- Generates byte enables and store-data lanes from the decoded memory_type and memory_rw encodings.
- Aligns and sign- or zero-extends load data.
- Sits between the pipeline stages and the memory model; the control unit's memory_type and memory_rw outputs drive the data port.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before the next grant is forced to fetch. Legal range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  32  fetch address (word aligned; bits [1:0] ignored)
- if_kill  in  1  discard the in-flight or pending fetch (taken branch/jump)
- if_ready  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request; held until d_ready
- d_addr  in  32  byte address
- d_rw  in  `MEM_WRITE_LEN  M_R / M_W / M_X
- d_type  in  `MEM_TYPE_LEN  MT_B/MT_H/MT_W/MT_BU/MT_HU/MT_X
- d_wdata  in  32  store data (low bits significant)
- d_ready  out  1  one-cycle pulse: access done
- d_err  out  1  qualifies d_ready: misaligned or illegal access
- d_rdata  out  32  aligned, extended load data
- mem_req  out  1  memory request; held until mem_ack
- mem_addr  out  32  word address ({addr[31:2],2'b00})
- mem_we  out  1  write
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-positioned store data
- mem_ack  in  1  memory completion; mem_rdata valid this cycle
- mem_rdata  in  32  read word

Behaviour:
- All outputs are registered.
- Reset values: every output 0; FSM in IDLE; starvation counter 0; kill flag 0.
- Reset mid-transaction: return to IDLE and drop mem_req the next cycle. No ready pulse is produced. Any mem_ack arriving while in IDLE is ignored.
- FSM states: IDLE, IF_BUSY, D_BUSY, D_ERR.
- Arbitration in IDLE, evaluated each cycle:
  - A data grant is chosen when d_req=1 and (if_req=0, or starve_cnt < STARVE_LIMIT).
  - Otherwise, a fetch grant is chosen when if_req=1 and if_kill=0.
  - Otherwise the FSM stays in IDLE.
- Starvation counter:
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant, or on a data grant with if_req=0.
  - Saturates at 255.
- Data-request legality, checked at grant:
  - Illegal if d_rw=M_X or d_type=MT_X.
  - Misaligned if H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - An illegal or misaligned request goes to D_ERR: no memory access. Next cycle d_ready=1 and d_err=1 for one cycle, then IDLE.
- Grant cycle: the next cycle has mem_req=1 with mem_addr, mem_we, mem_be and mem_wdata latched. These stay stable until the cycle mem_ack=1 is sampled.
- Completion:
  - On mem_ack, mem_req drops the next cycle and the owner's ready pulses in that same cycle. The FSM returns to IDLE, and a new grant may be made in that cycle.
  - Minimum request-to-ready latency: 3 cycles with a same-cycle ack.
  - Throughput: one access every 3 cycles at best.
- Store lanes:
  - B: be = 4'b0001<<a[1:0]; wdata = {4{d_wdata[7:0]}}.
  - H: be = 4'b0011<<{a[1],1'b0}; wdata = {2{d_wdata[15:0]}}.
  - W: be = 4'b1111.
- Loads: mem_we=0, be=4'b1111.
  - B/BU select byte a[1:0]; H/HU select half a[1]. These are sign-extended for B/H and zero-extended for BU/HU. W passes through.
  - Store completion: d_rdata=0.
- IF grants: mem_we=0, be=4'b1111, and if_rdata equals mem_rdata.
- if_kill:
  - In IF_BUSY, or coincident with the IF ack, sets the kill flag. On ack, no if_ready pulse occurs; the flag clears on return to IDLE.
  - In IDLE, blocks the fetch grant that cycle.
  - Has no effect on data transactions.
- Simultaneous if_req and d_req with starve_cnt < limit: data wins.
- A requester that drops req before ready violates the protocol; that behaviour is undefined.

Test Plan:
- LW, addr 0x100, mem_rdata=0xDEADBEEF, ack one cycle after mem_req -> mem_be=1111, mem_addr=0x100; d_ready with d_rdata=0xDEADBEEF and d_err=0, 4 cycles after d_req.
- LB, addr 0x103, rdata 0x80112233 -> d_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU, addr 0x102 -> 0x00008011.
- SB, addr 0x201, d_wdata=0x000000AB -> mem_we=1, mem_be=0010, mem_wdata=0xABABABAB. SH, addr 0x203 -> d_err=1, and mem_req never rises.
- if_req and d_req both held continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Fetch in flight, if_kill pulsed, ack 3 cycles later -> no if_ready; the next grant goes to the pending request.
- reset asserted while mem_req=1 and the ack has not arrived -> next cycle all outputs 0; a later mem_ack produces no ready pulse.
